// File: rtl/mmu_pkg.sv
// Shared MMU definitions: page geometry, PTE layout and the TLB controller states.
package mmu_pkg;
    localparam int PAGE_SHIFT      = 12;
    localparam int PTE_PRESENT_BIT = 0;

    typedef logic [63-PAGE_SHIFT:0] vpn_t;
    typedef logic [63-PAGE_SHIFT:0] ppn_t;

    typedef enum logic [1:0] {IDLE, LOOKUP, WALK, RESP} tlb_state_e;
endpackage

// File: rtl/mmu_tlb_if.sv
// TLB bus bundle: CPU request/response plus the walk handshake toward mmu.
interface mmu_tlb_if;
    logic        req_valid;
    logic [63:0] req_vaddr;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_paddr;
    logic        resp_fault;
    logic        flush;
    logic        walk_req;
    logic [63:0] walk_vaddr;
    logic        walk_done;
    logic [63:0] walk_pte;
    logic        walk_fault;

    // slave = the TLB, master = requester/walker side
    modport slave (
        input  req_valid, req_vaddr, flush, walk_done, walk_pte, walk_fault,
        output req_ready, resp_valid, resp_paddr, resp_fault, walk_req, walk_vaddr
    );
    modport master (
        output req_valid, req_vaddr, flush, walk_done, walk_pte, walk_fault,
        input  req_ready, resp_valid, resp_paddr, resp_fault, walk_req, walk_vaddr
    );
endinterface

// File: rtl/mmu_tlb_cam.sv
// TLB entry store: valid/VPN/PPN arrays, one write port, parallel VPN compare.
module mmu_tlb_cam
    import mmu_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       we_i,
    input  logic [$clog2(ENTRIES)-1:0] widx_i,
    input  vpn_t                       wvpn_i,
    input  ppn_t                       wppn_i,
    input  vpn_t                       lvpn_i,
    output logic                       hit_o,
    output ppn_t                       hit_ppn_o
);
    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] match;
    vpn_t               vpn_q [ENTRIES];
    ppn_t               ppn_q [ENTRIES];

    // flush outranks a same-cycle fill, leaving the written slot invalid
    always_ff @(posedge clk) begin
        if (reset || flush_i) valid_q <= '0;
        else if (we_i)        valid_q[widx_i] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            vpn_q[widx_i] <= wvpn_i;
            ppn_q[widx_i] <= wppn_i;
        end
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_cmp
        assign match[i] = valid_q[i] && (vpn_q[i] == lvpn_i);
    end

    // fills only follow misses, so at most one entry matches and OR-ing is exact
    always_comb begin
        hit_ppn_o = '0;
        for (int i = 0; i < ENTRIES; i++)
            if (match[i]) hit_ppn_o = hit_ppn_o | ppn_q[i];
    end

    assign hit_o = |match;
endmodule

// File: rtl/mmu_tlb.sv
// Fully associative TLB in front of mmu: FSM, round-robin victim, walk handshake.
// Optional hit/miss counters are built when MMU_TLB_STATS_EN is defined.
module mmu_tlb
    import mmu_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  logic        clk,
    input  logic        reset,
    mmu_tlb_if.slave    bus
`ifdef MMU_TLB_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);

    tlb_state_e       state_q, state_d;
    logic [63:0]      vaddr_q;
    ppn_t             ppn_q;
    logic             fault_q;
    logic [IDX_W-1:0] victim_q;
    logic             resp_valid_q, resp_fault_q, walk_req_q;
    logic [63:0]      resp_paddr_q;
    logic             cam_hit;
    ppn_t             cam_ppn;
    logic             idle_rdy, accept, lookup, walk_fin, walk_bad, fill_we;
    logic             pte_unused;

    assign pte_unused = ^bus.walk_pte[PAGE_SHIFT-1:1];

    mmu_tlb_cam #(.ENTRIES(ENTRIES)) u_cam (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (bus.flush),
        .we_i      (fill_we),
        .widx_i    (victim_q),
        .wvpn_i    (vaddr_q[63:PAGE_SHIFT]),
        .wppn_i    (bus.walk_pte[63:PAGE_SHIFT]),
        .lvpn_i    (vaddr_q[63:PAGE_SHIFT]),
        .hit_o     (cam_hit),
        .hit_ppn_o (cam_ppn)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.req_valid && idle_rdy) state_d = LOOKUP;
            LOOKUP:  state_d = cam_hit ? RESP : WALK;
            WALK:    if (bus.walk_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ready stays low through the registered response pulse
    always_comb begin
        idle_rdy = (state_q == IDLE) && !resp_valid_q;
        accept   = idle_rdy && bus.req_valid;
        lookup   = (state_q == LOOKUP);
        walk_fin = (state_q == WALK) && bus.walk_done;
        walk_bad = bus.walk_fault | ~bus.walk_pte[PTE_PRESENT_BIT];
        fill_we  = walk_fin && !walk_bad;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vaddr_q      <= '0;
            ppn_q        <= '0;
            fault_q      <= 1'b0;
            victim_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_paddr_q <= '0;
            resp_fault_q <= 1'b0;
            walk_req_q   <= 1'b0;
        end else begin
            if (accept) vaddr_q <= bus.req_vaddr;
            if (lookup && cam_hit) begin
                ppn_q   <= cam_ppn;
                fault_q <= 1'b0;
            end
            if (walk_fin) begin
                ppn_q   <= bus.walk_pte[63:PAGE_SHIFT];
                fault_q <= walk_bad;
            end
            if (fill_we) victim_q <= victim_q + 1'b1;
            walk_req_q   <= (state_q == WALK) && !bus.walk_done;
            resp_valid_q <= (state_q == RESP);
            if (state_q == RESP) begin
                resp_paddr_q <= fault_q ? 64'd0 : {ppn_q, vaddr_q[PAGE_SHIFT-1:0]};
                resp_fault_q <= fault_q;
            end
        end
    end

`ifdef MMU_TLB_STATS_EN
    logic [31:0] hits_q, misses_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (lookup) begin
            if (cam_hit) hits_q   <= hits_q + 32'd1;
            else         misses_q <= misses_q + 32'd1;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

    assign bus.req_ready  = idle_rdy;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_paddr = resp_paddr_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.walk_req   = walk_req_q;
    assign bus.walk_vaddr = vaddr_q;
endmodule

// File: tb/tb_mmu_tlb.sv
// Bench for mmu_tlb: directed vector table, reset-during-walk sequence, random run vs model.
module tb_mmu_tlb;
    localparam int ENTRIES = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mmu_tlb_if bus();

`ifdef MMU_TLB_STATS_EN
    logic [31:0] stat_hits, stat_misses;
    mmu_tlb #(.ENTRIES(ENTRIES)) dut (.clk(clk), .reset(reset), .bus(bus),
                                      .stat_hits(stat_hits), .stat_misses(stat_misses));
`else
    mmu_tlb #(.ENTRIES(ENTRIES)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] va;
        logic [63:0] pte;
        bit          wflt;
        bit          pre_fl;
        bit          fl_lk;
        bit          fl_done;
        bit          exp_walk;
        logic [63:0] exp_pa;
        bit          exp_flt;
    } vec_t;

    function automatic vec_t mk(logic [63:0] va, logic [63:0] pte, bit wflt, bit pre_fl,
                                bit fl_lk, bit fl_done, bit ew, logic [63:0] epa, bit ef);
        vec_t v;
        v.va = va; v.pte = pte; v.wflt = wflt; v.pre_fl = pre_fl; v.fl_lk = fl_lk;
        v.fl_done = fl_done; v.exp_walk = ew; v.exp_pa = epa; v.exp_flt = ef;
        return v;
    endfunction

    // One full request; walker answers dly cycles after walk_req is seen.
    task automatic xact(input logic [63:0] va, input logic [63:0] pte, input bit wflt,
                        input bit fl_lk, input bit fl_done, input int dly,
                        output bit walked, output logic [63:0] pa, output bit flt);
        int wr_cyc, done_cyc, rv_cyc, waitc;
        bit driving;
        walked = 0; pa = '0; flt = 0;
        wr_cyc = -1; done_cyc = -1; rv_cyc = -1; waitc = 0; driving = 0;
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_vaddr = va;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("req_ready_busy", 64'(bus.req_ready), 64'd0);
        if (fl_lk) bus.flush = 1'b1;
        for (int cyc = 1; cyc <= 64 && rv_cyc < 0; cyc++) begin
            @(posedge clk); #1;
            bus.flush = 1'b0;
            if (driving) begin
                driving = 0;
                done_cyc = cyc;
                bus.walk_done = 1'b0;
                bus.walk_fault = 1'b0;
                chk("walk_req_drop", 64'(bus.walk_req), 64'd0);
            end
            if (bus.walk_req && wr_cyc < 0) begin
                wr_cyc = cyc;
                walked = 1;
                chk("walk_vaddr", bus.walk_vaddr, va);
            end
            if (bus.walk_req && done_cyc < 0 && !driving) begin
                if (waitc == dly) begin
                    driving = 1;
                    bus.walk_done = 1'b1;
                    bus.walk_pte = pte;
                    bus.walk_fault = wflt;
                    bus.flush = fl_done;
                end
                waitc++;
            end
            if (bus.resp_valid) begin
                rv_cyc = cyc;
                pa = bus.resp_paddr;
                flt = bus.resp_fault;
                chk("ready_in_pulse", 64'(bus.req_ready), 64'd0);
            end
        end
        if (rv_cyc < 0) chk("resp_timeout", 64'd0, 64'd1);
        else if (!walked) chk("hit_latency", 64'(rv_cyc), 64'd2);
        else begin
            chk("walk_req_latency", 64'(wr_cyc), 64'd2);
            chk("miss_latency", 64'(rv_cyc), 64'(done_cyc + 1));
        end
        @(posedge clk); #1;
        chk("resp_pulse_1cyc", 64'(bus.resp_valid), 64'd0);
        chk("ready_after", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    function automatic logic [63:0] pte_of(logic [51:0] vpn);
        logic [51:0] ppn;
        ppn = vpn ^ 52'h00F0_F000_1234;
        return {ppn, 11'd0, ((vpn % 5) != 3)};
    endfunction

    // Reference model state: slot contents and round-robin victim index
    bit          m_vld [ENTRIES];
    logic [51:0] m_vpn [ENTRIES];
    logic [51:0] m_ppn [ENTRIES];
    int          m_vic;
    int          m_hits, m_misses;
    logic [51:0] pool [12];
    vec_t        tbl[$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit walked, flt, seen, ehit, efault, pre, lk, fd;
        logic [63:0] pa, va, pte, epa, tmp;
        logic [51:0] vpn, eppn;
        logic [11:0] off;
        int to, r;

        bus.req_valid = 0; bus.req_vaddr = '0; bus.flush = 0;
        bus.walk_done = 0; bus.walk_pte = '0; bus.walk_fault = 0;
        do_reset();
        chk("rst_req_ready",  64'(bus.req_ready),  64'd1);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_paddr", bus.resp_paddr,      64'd0);
        chk("rst_resp_fault", 64'(bus.resp_fault), 64'd0);
        chk("rst_walk_req",   64'(bus.walk_req),   64'd0);
        chk("rst_walk_vaddr", bus.walk_vaddr,      64'd0);

        //              va        pte       wf pf lk fd walk pa        flt
        tbl.push_back(mk(64'h5123, 64'hA001, 0, 0, 0, 0, 1, 64'hA123, 0));
        tbl.push_back(mk(64'h5FFF, 64'hA001, 0, 0, 0, 0, 0, 64'hAFFF, 0));
        tbl.push_back(mk(64'h7000, 64'h8000, 0, 0, 0, 0, 1, 64'h0,    1));
        tbl.push_back(mk(64'h7000, 64'h8000, 0, 0, 0, 0, 1, 64'h0,    1));
        tbl.push_back(mk(64'h6010, 64'h6001, 1, 0, 0, 0, 1, 64'h0,    1));
        for (int k = 0; k <= ENTRIES; k++)
            tbl.push_back(mk(64'((64'h10 + k) << 12) | 64'h0AB, 64'(((64'h200 + k) << 12) | 64'h1),
                             0, (k == 0), 0, 0, 1, 64'(((64'h200 + k) << 12) | 64'h0AB), 0));
        tbl.push_back(mk(64'h10000, 64'h200001, 0, 0, 0, 0, 1, 64'h200000, 0));
        tbl.push_back(mk(64'((64'h10 + ENTRIES) << 12) | 64'h0AB, 64'h0, 0, 0, 0, 0, 0,
                         64'(((64'h200 + ENTRIES) << 12) | 64'h0AB), 0));
        tbl.push_back(mk(64'h5000, 64'hA001, 0, 0, 0, 0, 1, 64'hA000, 0));
        tbl.push_back(mk(64'h5444, 64'hA001, 0, 0, 1, 0, 0, 64'hA444, 0));
        tbl.push_back(mk(64'h5000, 64'hA001, 0, 0, 0, 0, 1, 64'hA000, 0));
        tbl.push_back(mk(64'h9000, 64'hB001, 0, 0, 0, 1, 1, 64'hB000, 0));
        tbl.push_back(mk(64'h9000, 64'hB001, 0, 0, 0, 0, 1, 64'hB000, 0));
        tbl.push_back(mk(64'h5000, 64'hA001, 0, 0, 0, 0, 1, 64'hA000, 0));

        foreach (tbl[i]) begin
            if (tbl[i].pre_fl) begin
                bus.flush = 1'b1;
                @(posedge clk); #1 bus.flush = 1'b0;
            end
            xact(tbl[i].va, tbl[i].pte, tbl[i].wflt, tbl[i].fl_lk, tbl[i].fl_done, i % 3,
                 walked, pa, flt);
            chk($sformatf("v%0d_walk", i),  64'(walked), 64'(tbl[i].exp_walk));
            chk($sformatf("v%0d_paddr", i), pa,          tbl[i].exp_pa);
            chk($sformatf("v%0d_fault", i), 64'(flt),    64'(tbl[i].exp_flt));
        end

        // reset while the walk is outstanding, then a late walk_done
        bus.req_valid = 1'b1; bus.req_vaddr = 64'h3000;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        to = 0;
        while (!bus.walk_req && to < 10) begin
            @(posedge clk); #1;
            to++;
        end
        chk("rw_walk_req_seen", 64'(bus.walk_req), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("rw_walk_req_dropped", 64'(bus.walk_req), 64'd0);
        bus.walk_done = 1'b1; bus.walk_pte = 64'h4001;
        @(posedge clk); #1 bus.walk_done = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.resp_valid || bus.walk_req) seen = 1;
            @(posedge clk); #1;
        end
        chk("rw_no_resp_no_walk", 64'(seen), 64'd0);
        chk("rw_ready", 64'(bus.req_ready), 64'd1);
        xact(64'h5000, 64'hA001, 0, 0, 0, 1, walked, pa, flt);
        chk("rw_cold_walk",  64'(walked), 64'd1);
        chk("rw_cold_paddr", pa,          64'hA000);

        // randomized run against the reference model
        do_reset();
        for (int i = 0; i < ENTRIES; i++) m_vld[i] = 0;
        m_vic = 0; m_hits = 0; m_misses = 0;
        for (int i = 0; i < 12; i++) begin
            tmp = {$urandom, $urandom};
            pool[i] = {tmp[51:4], 4'(i)};
        end
        for (int t = 0; t < 300; t++) begin
            vpn = pool[$urandom_range(0, 11)];
            off = 12'($urandom_range(0, 4095));
            va  = {vpn, off};
            pte = pte_of(vpn);
            r   = $urandom_range(0, 19);
            pre = (r == 0); lk = (r == 1); fd = (r == 2);
            if (pre) begin
                for (int i = 0; i < ENTRIES; i++) m_vld[i] = 0;
                bus.flush = 1'b1;
                @(posedge clk); #1 bus.flush = 1'b0;
            end
            ehit = 0; eppn = '0;
            for (int i = 0; i < ENTRIES; i++)
                if (m_vld[i] && m_vpn[i] == vpn) begin ehit = 1; eppn = m_ppn[i]; end
            if (lk) for (int i = 0; i < ENTRIES; i++) m_vld[i] = 0;
            efault = 0;
            if (ehit) begin
                m_hits++;
                epa = {eppn, off};
            end else begin
                m_misses++;
                efault = ((vpn % 7) == 6) || !pte[0];
                epa = efault ? 64'd0 : {pte[63:12], off};
                if (!efault) begin
                    m_vpn[m_vic] = vpn; m_ppn[m_vic] = pte[63:12]; m_vld[m_vic] = 1;
                    m_vic = (m_vic + 1) % ENTRIES;
                end
                if (fd) for (int i = 0; i < ENTRIES; i++) m_vld[i] = 0;
            end
            xact(va, pte, ((vpn % 7) == 6), lk, fd, $urandom_range(0, 3), walked, pa, flt);
            chk($sformatf("r%0d_walk", t),  64'(walked), 64'(!ehit));
            chk($sformatf("r%0d_paddr", t), pa,          epa);
            chk($sformatf("r%0d_fault", t), 64'(flt),    64'(efault));
        end
`ifdef MMU_TLB_STATS_EN
        chk("stat_hits",   64'(stat_hits),   64'(m_hits));
        chk("stat_misses", 64'(stat_misses), 64'(m_misses));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mmu_tlb.md
# mmu_tlb

Fully associative translation lookaside buffer placed directly upstream of `mmu`, between the CPU address path and the page-structure walker. A hit returns the translated physical address without a walk. A miss issues one walk request to `mmu`, waits for its result, fills an entry, and returns the address. A page fault reported by the walk is passed through to the requester, and the faulting translation is never cached.

## Interface
- `ENTRIES`, default 8: number of TLB entries; must be a power of two and at least 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: translation request present.
- `req_vaddr`  in  64: virtual address to translate.
- `req_ready`  out  1: TLB can accept a request; high only in IDLE.
- `resp_valid`  out  1: one-cycle pulse; `resp_paddr` and `resp_fault` are valid while it is high.
- `resp_paddr`  out  64: translated address, `{ppn, vaddr[11:0]}`.
- `resp_fault`  out  1: page fault for the request.
- `flush`  in  1: invalidate all entries.
- `walk_req`  out  1: walk request to `mmu`; held high until `walk_done`.
- `walk_vaddr`  out  64: address to walk; stable while `walk_req` is high.
- `walk_done`  in  1: walk completed; sampled only in the WALK state.
- `walk_pte`  in  64: final leaf entry; bit 0 = present, bits 63:12 = PPN.
- `walk_fault`  in  1: walker fault (`pgft` from `mmu`).

## Operation
- Page size is 4 KiB. VPN is `vaddr[63:12]` (52 bits) and PPN is `pte[63:12]`.
- Each entry holds a valid bit, a VPN and a PPN. A victim pointer selects replacements in round-robin order.
- State IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch `req_vaddr` and go to LOOKUP.
- State LOOKUP: compare the latched VPN against all valid entries in parallel.
  - Hit: go to RESP with the hit PPN and fault = 0.
  - Miss: go to WALK.
- State WALK:
  - `walk_req` = 1 and `walk_vaddr` = latched address.
  - On `walk_done`, a fault is `walk_fault | ~walk_pte[0]`.
  - On a fault: go to RESP with fault = 1 and `resp_paddr` = 0. No fill.
  - Otherwise: write {valid, VPN, PPN} into the victim entry, increment the victim pointer (wrapping from `ENTRIES-1` to 0), and go to RESP.
- State RESP:
  - `resp_valid` = 1 for exactly one cycle, then return to IDLE.
  - There is no response backpressure.
- Duplicate VPNs cannot occur, because a fill only happens after a miss.
- Flush:
  - Clears every valid bit at the next edge, in any state; the victim pointer is unchanged.
  - Flush in the same cycle as a fill: flush wins and the entry is left invalid; the response is still delivered.
  - Flush during LOOKUP: the compare in that cycle still uses the pre-flush contents.
- Reset:
  - State = IDLE, all valid bits = 0, victim pointer = 0.
  - Reset in the middle of a walk drops `walk_req` the following cycle. A late `walk_done` arriving in IDLE is ignored.

## Timing
- Reset values: `req_ready` = 1, `resp_valid` = 0, `resp_paddr` = 0, `resp_fault` = 0, `walk_req` = 0, `walk_vaddr` = 0.
- All outputs are driven from registers or directly decoded from the state register; there is no combinational path from any input to any output.
- Hit latency: request accepted at edge N; `resp_valid` is high during the cycle after edge N+2.
- Miss latency: `walk_req` rises after edge N+2. If `walk_done` is sampled at edge M, `resp_valid` is high after edge M+1.
- Throughput: at most one request in flight. `req_ready` is low from acceptance until the cycle after the RESP pulse.

## Configuration
- `MMU_TLB_STATS_EN` defined:
  - Adds 32-bit outputs `stat_hits` and `stat_misses`.
  - Each counter increments once per LOOKUP outcome, wraps at 2^32, and clears on reset. Flush does not clear them.
  - Walk faults count as misses.
- Without the macro: the ports and counters do not exist and behaviour is otherwise identical.

## Structure
- Shared package `mmu_pkg`: `PAGE_SHIFT = 12`, `vpn_t` (52-bit), `ppn_t` (52-bit), `PTE_PRESENT_BIT = 0`, and the TLB state enum (IDLE, LOOKUP, WALK, RESP). `mmu` is also to import this package.
- Sub-module `mmu_tlb_cam`:
  - Holds the entry array, valid bits and parallel compare, plus the write port.
  - Outputs hit and hit PPN.
- `mmu_tlb` keeps the FSM, the victim pointer, the walk handshake and the optional counters.

## Test plan
- Reset, then request 0x5123 -> LOOKUP miss and `walk_req` with `walk_vaddr` = 0x5123. Drive `walk_pte` = 0xA001 with `walk_done` -> one `resp_valid` pulse with `resp_paddr` = 0xA123 and fault = 0.
- Repeat the request for 0x5FFF -> `walk_req` never rises; `resp_paddr` = 0xAFFF two cycles after acceptance.
- Request 0x7000 and return `walk_pte` = 0x8000 (present = 0) -> `resp_fault` = 1 and `resp_paddr` = 0. A repeated 0x7000 request walks again.
- Fill VPNs 0x10 through 0x10+`ENTRIES` -> the first VPN is evicted (the pointer wraps to 0). A request for 0x10000 walks again; the VPN filled last still hits.
- `flush` asserted in the same cycle as `walk_done` for 0x9000 -> the response is delivered with PPN valid; a following request for 0x9000 walks again, and previously cached 0x5000 also walks.
- Assert `reset` while in WALK, then pulse `walk_done` a cycle later -> no `resp_valid`, `walk_req` = 0, `req_ready` = 1, and the next request behaves as a cold miss.
